rs_encoder_255_251: RTL and testbench

- Systematic Reed-Solomon RS(255,251) encoder over GF(2^8), t=2.
- Takes a byte stream framed by sop/eop and passes the data through unchanged.
- Appends 4 parity bytes after the last data byte.
- Sits in the transmit path in front of the matching RS decoder; a streaming source drives it and honours the busy back-pressure.

---
 rtl/rs_encoder_255_251.sv | 255 +++++++++++++++++++++++++
 tb/tb_rs_encoder_255_251.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_encoder_255_251.sv
// ---------------------------------------------------------------------------
// rs_encoder_255_251
//
// Systematic Reed-Solomon RS(255,251) encoder over GF(2^8), t = 2.
// Data bytes framed by din_sop/din_eop are echoed one cycle later and the
// four parity bytes (P3 first, P0 last) follow directly after the last data
// byte. While parity is being emitted busy is high and input is ignored.
//
// Field: primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02.
// Generator: g(x) = x^4 + 15x^3 + 54x^2 + 120x + 64.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   din_val   in   input byte valid
//   din_sop   in   first data byte of a block
//   din_eop   in   last data byte of a block
//   din[7:0]  in   data byte
//   dout_val  out  output byte valid (data or parity)
//   dout_sop  out  first output byte of the codeword
//   dout_eop  out  last parity byte
//   dout[7:0] out  codeword byte
//   busy      out  high while parity is emitted (input ignored)
//
// Build option:
//   RS_ENC_OUT_REG_EN  adds a second register stage on dout/dout_val/
//                      dout_sop/dout_eop (+1 cycle latency, busy unchanged).
// ---------------------------------------------------------------------------
module rs_encoder_255_251 #(
  parameter int NN = 255,
  parameter int KK = 251,
  parameter int TT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din_val,
  input  logic       din_sop,
  input  logic       din_eop,
  input  logic [7:0] din,
  output logic       dout_val,
  output logic       dout_sop,
  output logic       dout_eop,
  output logic [7:0] dout,
  output logic       busy
);

  // Symbol counter wide enough to hold a full codeword length.
  localparam int CW = $clog2(NN + 1);
  // Index of the last parity byte within the parity phase.
  localparam logic [1:0] PAR_LAST = 2'(2 * TT - 1);
  localparam logic [CW-1:0] KK_CNT = CW'(KK);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // GF(2^8) multiply. Every call below has a constant second operand, so
  // this folds into a fixed XOR network on the first operand.
  // -------------------------------------------------------------------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return acc;
  endfunction

  // Generator coefficient feeding register r<i>.
  function automatic logic [7:0] gen_coef(input int i);
    logic [7:0] c;
    case (i)
      0:       c = 8'd64;
      1:       c = 8'd120;
      2:       c = 8'd54;
      default: c = 8'd15;
    endcase
    return c;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t          state_reg,    state_next;
  logic [1:0]      par_cnt_reg,  par_cnt_next;
  logic [CW-1:0]   sym_cnt_reg,  sym_cnt_next;
  logic [3:0][7:0] lfsr_reg,     lfsr_next;

  logic [7:0]      dout_reg,     dout_next;
  logic            dout_val_reg, dout_val_next;
  logic            dout_sop_reg, dout_sop_next;
  logic            dout_eop_reg, dout_eop_next;

  // -------------------------------------------------------------------------
  // LFSR datapath
  // -------------------------------------------------------------------------
  logic            accept;
  logic            restart;
  logic [3:0][7:0] lfsr_base;
  logic [3:0][7:0] lfsr_upd;
  logic [3:0][7:0] lfsr_shift;
  logic [3:0][7:0] fb_prod;
  logic [7:0]      fb;
  logic [CW-1:0]   sym_cnt_inc;

  assign busy    = (state_reg == S_PAR);
  assign accept  = din_val && !busy;
  // A sop byte always starts from an empty remainder, whether it opens a
  // block from IDLE or restarts one in the middle of DATA.
  assign restart = accept && din_sop;

  assign lfsr_base   = restart ? '0 : lfsr_reg;
  assign fb          = din ^ lfsr_base[3];
  assign lfsr_shift  = {lfsr_reg[2:0], 8'h00};
  assign sym_cnt_inc = restart ? CW'(1) : sym_cnt_reg + CW'(1);

  for (genvar gi = 0; gi < 4; gi++) begin : g_tap
    assign fb_prod[gi] = gf_mul(fb, gen_coef(gi));
    if (gi == 0) begin : g_first
      assign lfsr_upd[gi] = fb_prod[gi];
    end else begin : g_rest
      assign lfsr_upd[gi] = lfsr_base[gi-1] ^ fb_prod[gi];
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and output-register logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    par_cnt_next  = par_cnt_reg;
    sym_cnt_next  = sym_cnt_reg;
    lfsr_next     = lfsr_reg;
    dout_next     = dout_reg;
    dout_val_next = 1'b0;
    dout_sop_next = 1'b0;
    dout_eop_next = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // Bytes arriving without sop outside a block are dropped.
        if (restart) begin
          lfsr_next     = lfsr_upd;
          sym_cnt_next  = sym_cnt_inc;
          dout_next     = din;
          dout_val_next = 1'b1;
          dout_sop_next = 1'b1;
          if (din_eop || sym_cnt_inc == KK_CNT) begin
            state_next   = S_PAR;
            par_cnt_next = 2'd0;
          end else begin
            state_next = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          lfsr_next     = lfsr_upd;
          sym_cnt_next  = sym_cnt_inc;
          dout_next     = din;
          dout_val_next = 1'b1;
          dout_sop_next = din_sop;
          // A full block closes itself even if eop never arrives.
          if (din_eop || sym_cnt_inc == KK_CNT) begin
            state_next   = S_PAR;
            par_cnt_next = 2'd0;
          end
        end
      end

      S_PAR: begin
        // Shift the remainder out MSB register first; zero-fill so the
        // LFSR is empty by the time the block finishes.
        dout_next     = lfsr_reg[3];
        dout_val_next = 1'b1;
        lfsr_next     = lfsr_shift;
        par_cnt_next  = par_cnt_reg + 2'd1;
        if (par_cnt_reg == PAR_LAST) begin
          dout_eop_next = 1'b1;
          state_next    = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      par_cnt_reg  <= 2'd0;
      sym_cnt_reg  <= '0;
      lfsr_reg     <= '0;
      dout_reg     <= 8'h00;
      dout_val_reg <= 1'b0;
      dout_sop_reg <= 1'b0;
      dout_eop_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      par_cnt_reg  <= par_cnt_next;
      sym_cnt_reg  <= sym_cnt_next;
      lfsr_reg     <= lfsr_next;
      dout_reg     <= dout_next;
      dout_val_reg <= dout_val_next;
      dout_sop_reg <= dout_sop_next;
      dout_eop_reg <= dout_eop_next;
    end
  end

  // -------------------------------------------------------------------------
  // Output stage
  // -------------------------------------------------------------------------
`ifdef RS_ENC_OUT_REG_EN
  logic [7:0] dout_q_reg;
  logic       dout_val_q_reg;
  logic       dout_sop_q_reg;
  logic       dout_eop_q_reg;

  // Extra retiming stage; busy stays tied to the FSM so the source sees
  // the same back-pressure window as the single-stage build.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q_reg     <= 8'h00;
      dout_val_q_reg <= 1'b0;
      dout_sop_q_reg <= 1'b0;
      dout_eop_q_reg <= 1'b0;
    end else begin
      dout_q_reg     <= dout_reg;
      dout_val_q_reg <= dout_val_reg;
      dout_sop_q_reg <= dout_sop_reg;
      dout_eop_q_reg <= dout_eop_reg;
    end
  end

  assign dout     = dout_q_reg;
  assign dout_val = dout_val_q_reg;
  assign dout_sop = dout_sop_q_reg;
  assign dout_eop = dout_eop_q_reg;
`else
  assign dout     = dout_reg;
  assign dout_val = dout_val_reg;
  assign dout_sop = dout_sop_reg;
  assign dout_eop = dout_eop_reg;
`endif

endmodule

// File: tb/tb_rs_encoder_255_251.sv
// ---------------------------------------------------------------------------
// tb_rs_encoder_255_251
//
// Directed bench for rs_encoder_255_251 (default build, single output
// register stage). Inputs are driven 1 time unit after each rising edge,
// outputs are captured on the falling edge into a byte queue.
// ---------------------------------------------------------------------------
module tb_rs_encoder_255_251;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din_val = 1'b0;
  logic       din_sop = 1'b0;
  logic       din_eop = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dout_val;
  logic       dout_sop;
  logic       dout_eop;
  logic [7:0] dout;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  rs_encoder_255_251 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .din_val  (din_val),
    .din_sop  (din_sop),
    .din_eop  (din_eop),
    .din      (din),
    .dout_val (dout_val),
    .dout_sop (dout_sop),
    .dout_eop (dout_eop),
    .dout     (dout),
    .busy     (busy)
  );

  // Output capture
  logic [7:0] cap_q[$];
  logic       cap_sop_q[$];
  logic       cap_eop_q[$];
  int         cap_cyc_q[$];
  bit         cap_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cap_en && dout_val) begin
      cap_q.push_back(dout);
      cap_sop_q.push_back(dout_sop);
      cap_eop_q.push_back(dout_eop);
      cap_cyc_q.push_back(cyc);
    end
  end

  task automatic cap_clear();
    cap_q.delete();
    cap_sop_q.delete();
    cap_eop_q.delete();
    cap_cyc_q.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic e, input logic [7:0] d);
    din_val = v;
    din_sop = s;
    din_eop = e;
    din     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Independent GF(2^8) multiply, 0x11D.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // Codeword evaluated at x (first captured byte is the highest power).
  function automatic logic [7:0] synd(input int start, input int len, input logic [7:0] x);
    logic [7:0] s;
    s = 8'h00;
    for (int i = start; i < start + len; i++) s = gmul(s, x) ^ cap_q[i];
    return s;
  endfunction

  int         bad;
  int         n_eop;
  logic [7:0] acc;
  logic [7:0] exp_par2 [4];

  initial begin
    exp_par2[0] = 8'd30;
    exp_par2[1] = 8'd108;
    exp_par2[2] = 8'd240;
    exp_par2[3] = 8'd128;

    // ---------------- reset state ----------------
    idle(3);
    chk("rst_dout_val", dout_val, 1'b0);
    chk("rst_dout_sop", dout_sop, 1'b0);
    chk("rst_dout_eop", dout_eop, 1'b0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    idle(2);

    // ---------------- single byte 0x01, cycle by cycle ----------------
    drive(1'b1, 1'b1, 1'b1, 8'h01);
    din_val = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    chk("sb_data", dout, 8'h01);
    chk("sb_data_val", dout_val, 1'b1);
    chk("sb_data_sop", dout_sop, 1'b1);
    chk("sb_busy0", busy, 1'b1);
    idle(1);
    chk("sb_p3", dout, 8'd15);
    chk("sb_p3_sop", dout_sop, 1'b0);
    chk("sb_p3_eop", dout_eop, 1'b0);
    chk("sb_busy1", busy, 1'b1);
    idle(1);
    chk("sb_p2", dout, 8'd54);
    chk("sb_busy2", busy, 1'b1);
    idle(1);
    chk("sb_p1", dout, 8'd120);
    chk("sb_busy3", busy, 1'b1);
    idle(1);
    chk("sb_p0", dout, 8'd64);
    chk("sb_p0_val", dout_val, 1'b1);
    chk("sb_p0_eop", dout_eop, 1'b1);
    chk("sb_busy_end", busy, 1'b0);
    idle(1);
    chk("sb_idle_val", dout_val, 1'b0);
    chk("sb_idle_eop", dout_eop, 1'b0);
    chk("sb_idle_hold", dout, 8'd64);
    $display("txn single_byte_01 done");

    // ---------------- all-zero full block ----------------
    cap_clear();
    cap_en = 1'b1;
    for (int i = 0; i < 251; i++) drive(1'b1, i == 0, i == 250, 8'h00);
    idle(8);
    chk("zero_len", cap_q.size(), 255);
    bad = 0;
    n_eop = 0;
    foreach (cap_q[i]) begin
      if (cap_q[i] !== 8'h00) bad++;
      if (cap_eop_q[i]) n_eop++;
    end
    chk("zero_nonzero_bytes", bad, 0);
    chk("zero_eop_count", n_eop, 1);
    if (cap_q.size() == 255) begin
      chk("zero_sop_first", cap_sop_q[0], 1'b1);
      chk("zero_eop_last", cap_eop_q[254], 1'b1);
    end
    $display("txn all_zero block bytes=%0d", cap_q.size());

    // ---------------- descending block, junk during busy, then 0x02 ----------------
    cap_clear();
    for (int i = 0; i < 251; i++) drive(1'b1, i == 0, i == 250, 8'(251 - i));
    // busy window: four accepted-looking bytes, even one claiming sop
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 1'b0, 8'hAA);
    drive(1'b1, 1'b1, 1'b1, 8'h02);
    idle(8);
    chk("desc_len", cap_q.size(), 260);
    if (cap_q.size() == 260) begin
      bad = 0;
      for (int i = 0; i < 251; i++) if (cap_q[i] !== 8'(251 - i)) bad++;
      chk("desc_echo", bad, 0);
      chk("desc_sop", cap_sop_q[0], 1'b1);
      chk("desc_eop", cap_eop_q[254], 1'b1);
      chk("desc_s0", synd(0, 255, 8'h01), 8'h00);
      chk("desc_s1", synd(0, 255, 8'h02), 8'h00);
      chk("desc_s2", synd(0, 255, 8'h04), 8'h00);
      chk("desc_s3", synd(0, 255, 8'h08), 8'h00);
      acc = 8'h00;
      for (int i = 0; i < 255; i++) acc = acc ^ cap_q[i];
      chk("desc_xor", acc, 8'h00);
      chk("desc_contig", cap_cyc_q[254] - cap_cyc_q[0], 254);
      chk("junk_next_data", cap_q[255], 8'h02);
      chk("junk_next_sop", cap_sop_q[255], 1'b1);
      for (int i = 0; i < 4; i++) chk("junk_next_par", cap_q[256 + i], exp_par2[i]);
      chk("junk_next_eop", cap_eop_q[259], 1'b1);
      chk("junk_next_gap", cap_cyc_q[255] - cap_cyc_q[254], 1);
    end
    $display("txn descending+junk bytes=%0d", cap_q.size());

    // ---------------- back-to-back blocks ----------------
    cap_clear();
    for (int i = 0; i < 10; i++) drive(1'b1, i == 0, i == 9, 8'(i + 1));
    idle(4);
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0, i == 4, 8'(8'h55 + 8'(i * 17)));
    idle(8);
    chk("b2b_len", cap_q.size(), 23);
    if (cap_q.size() == 23) begin
      chk("b2b_contig", cap_cyc_q[22] - cap_cyc_q[0], 22);
      chk("b2b_a_sop", cap_sop_q[0], 1'b1);
      chk("b2b_a_eop", cap_eop_q[13], 1'b1);
      chk("b2b_b_sop", cap_sop_q[14], 1'b1);
      chk("b2b_b_eop", cap_eop_q[22], 1'b1);
      chk("b2b_b_first", cap_q[14], 8'h55);
      for (int j = 0; j < 4; j++) begin
        chk("b2b_a_synd", synd(0, 14, 8'(1 << j)), 8'h00);
        chk("b2b_b_synd", synd(14, 9, 8'(1 << j)), 8'h00);
      end
    end
    $display("txn back_to_back bytes=%0d", cap_q.size());

    // ---------------- reset mid-block ----------------
    cap_clear();
    for (int i = 0; i < 100; i++) drive(1'b1, i == 0, 1'b0, 8'(i + 7));
    din_val = 1'b0; din_sop = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mrst_dout_val", dout_val, 1'b0);
    chk("mrst_dout", dout, 8'h00);
    chk("mrst_busy", busy, 1'b0);
    idle(2);
    rst_n = 1'b1;
    cap_clear();
    idle(6);
    chk("mrst_no_parity", cap_q.size(), 0);
    drive(1'b1, 1'b1, 1'b1, 8'h01);
    idle(8);
    chk("mrst_next_len", cap_q.size(), 5);
    if (cap_q.size() == 5) begin
      chk("mrst_next_d", cap_q[0], 8'h01);
      chk("mrst_next_p3", cap_q[1], 8'd15);
      chk("mrst_next_p2", cap_q[2], 8'd54);
      chk("mrst_next_p1", cap_q[3], 8'd120);
      chk("mrst_next_p0", cap_q[4], 8'd64);
      chk("mrst_next_eop", cap_eop_q[4], 1'b1);
    end
    $display("txn reset_mid_block then single_byte bytes=%0d", cap_q.size());

    cap_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
